// File: rtl/seg7_readback_if.sv
// Segment readback bus: sampled pattern in, committed decode out.
interface seg7_readback_if;
  logic [7:0] hex;
  logic       pointld;
  logic [2:0] num;
  logic [7:0] sw_out;
  logic       valid;
  logic       err;
  logic [7:0] chg_cnt;

  modport master (
    output hex,
    output pointld,
    input  num,
    input  sw_out,
    input  valid,
    input  err,
    input  chg_cnt
  );

  modport slave (
    input  hex,
    input  pointld,
    output num,
    output sw_out,
    output valid,
    output err,
    output chg_cnt
  );
endinterface

// File: rtl/seg7_readback.sv
// Debounced 7-segment pattern decoder with committed switch image.
// Optional change counter enabled by macro SEG7_READBACK_CNT_EN.
module seg7_readback #(
  parameter int unsigned STABLE = 4
) (
  input  logic           clk,
  input  logic           rst,
  seg7_readback_if.slave bus
);

  typedef enum logic {SETTLE, HOLD} state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  state_t     state, state_n;
  logic [7:0] hex_q, hex_n;
  logic       pd_q, pd_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] num_q, num_n;
  logic [7:0] sw_q, sw_n;
  logic       valid_q, valid_n;
  logic       err_q, err_n;
  logic       commit;
  logic [7:0] c_hex;
  logic       c_pd;
  logic       legal;
  logic [2:0] digit;
  logic       diff;
  logic [3:0] cnt_inc;

  function automatic logic [3:0] decode(input logic [7:0] h);
    logic [3:0] r;
    unique case (h)
      8'h02:   r = 4'b1_000;
      8'h9F:   r = 4'b1_001;
      8'h25:   r = 4'b1_010;
      8'h0D:   r = 4'b1_011;
      8'h99:   r = 4'b1_100;
      8'h49:   r = 4'b1_101;
      8'h41:   r = 4'b1_110;
      8'h1F:   r = 4'b1_111;
      default: r = 4'b0_000;
    endcase
    return r;
  endfunction

  assign diff    = {bus.hex, bus.pointld} != {hex_q, pd_q};
  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    state_n = state;
    hex_n   = hex_q;
    pd_n    = pd_q;
    cnt_n   = cnt;
    num_n   = num_q;
    sw_n    = sw_q;
    valid_n = valid_q;
    err_n   = err_q;
    commit  = 1'b0;
    c_hex   = hex_q;
    c_pd    = pd_q;
    if (diff) begin
      hex_n   = bus.hex;
      pd_n    = bus.pointld;
      cnt_n   = 4'd1;
      state_n = SETTLE;
      // A run of one is complete on the edge it starts
      if (STABLE_C == 4'd1) begin
        commit  = 1'b1;
        c_hex   = bus.hex;
        c_pd    = bus.pointld;
        state_n = HOLD;
      end
    end else if (state == SETTLE) begin
      cnt_n = cnt_inc;
      if (cnt_inc == STABLE_C) begin
        commit  = 1'b1;
        state_n = HOLD;
      end
    end
    {legal, digit} = decode(c_hex);
    if (commit) begin
      if (legal) begin
        num_n   = digit;
        err_n   = 1'b0;
        valid_n = c_pd;
        sw_n    = c_pd ? (8'h01 << digit) : 8'h00;
      end else begin
        err_n   = 1'b1;
        valid_n = 1'b0;
        sw_n    = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SETTLE;
      hex_q   <= 8'hFF;
      pd_q    <= 1'b0;
      cnt     <= 4'd0;
      num_q   <= 3'd0;
      sw_q    <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      hex_q   <= hex_n;
      pd_q    <= pd_n;
      cnt     <= cnt_n;
      num_q   <= num_n;
      sw_q    <= sw_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

`ifdef SEG7_READBACK_CNT_EN
  logic [7:0] chg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_q <= 8'h00;
    end else if (commit &&
                 {num_n, valid_n, err_n} !=
                 {num_q, valid_q, err_q}) begin
      chg_q <= chg_q + 8'd1;
    end
  end

  assign bus.chg_cnt = chg_q;
`else
  assign bus.chg_cnt = 8'h00;
`endif

  assign bus.num    = num_q;
  assign bus.sw_out = sw_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;

endmodule

// File: doc/seg7_readback.md
SEG7_READBACK -- requirements
Module: seg7_readback

Interface
REQ-001 Parameter STABLE, default 4, range 1..15: consecutive identical samples required before a value is committed.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 hex  input  8  active-low segment pattern, bit7=a … bit1=g, bit0=dp.
REQ-005 pointld  input  1  source "any switch set" indication.
REQ-006 num  output  3  committed decoded digit, registered.
REQ-007 sw_out  output  8  committed one-hot switch image, registered.
REQ-008 valid  output  1  committed pointld, registered.
REQ-009 err  output  1  committed pattern is not a legal digit, registered.
REQ-010 chg_cnt  output  8  count of committed value changes, registered.

Function
REQ-011 Decode table (hex -> digit) SHALL be exactly: 02->0, 9F->1, 25->2, 0D->3, 99->4, 49->5, 41->6, 1F->7; any other 8-bit value SHALL be illegal.
REQ-012 Block SHALL hold a sample register {hex_q, pd_q} and a 4-bit run counter cnt.
REQ-013 States: SETTLE (counting identical samples) and HOLD (value committed, waiting for change).
REQ-014 On any edge where {hex, pointld} != {hex_q, pd_q}: load sample register, cnt<=1, state<=SETTLE, no commit.
REQ-015 On an edge in SETTLE with input equal to the sample: cnt<=cnt+1.
REQ-016 Commit SHALL occur on the edge where cnt reaches STABLE (the first-sample edge counts as 1); state<=HOLD on that edge.
REQ-017 With STABLE=1, commit SHALL occur on the first-sample edge itself.
REQ-018 In HOLD with input equal to the sample: no state change, no further commit, cnt frozen.
REQ-019 Commit of a legal pattern: num<=digit, err<=0, valid<=pd_q, sw_out<=(pd_q ? one-hot(digit) : 8'h00).
REQ-020 Commit of an illegal pattern: err<=1, valid<=0, sw_out<=8'h00, num unchanged.
REQ-021 An input change on the edge that would otherwise commit SHALL win: the sample is reloaded and no commit happens.
REQ-022 Outputs SHALL change only on commit edges or on reset; glitches shorter than STABLE samples SHALL never reach outputs.

Reset
REQ-023 rst=1 at an edge: num=0, sw_out=8'h00, valid=0, err=0, chg_cnt=0, hex_q=8'hFF, pd_q=0, cnt=0, state=SETTLE.
REQ-024 Reset SHALL take priority over every other update, including a commit on the same edge.
REQ-025 Reset mid-SETTLE SHALL discard the partial run; counting restarts from the post-reset sample.
REQ-026 After reset, input held at 8'hFF with pointld=0 SHALL count as equal to the sample and commit err=1 after STABLE edges.

Configuration
REQ-027 Macro SEG7_READBACK_CNT_EN defined: chg_cnt increments by 1, wrapping 255->0, on each commit whose {num, valid, err} differs from the previous committed value.
REQ-028 Macro not defined: counter logic absent; chg_cnt SHALL be constant 8'h00; all other behaviour identical.

Verification
REQ-029 Reset, then hex=8'h99, pointld=1 held, STABLE=4 -> at the 4th edge after it is first sampled: num=4, sw_out=8'h10, valid=1, err=0; chg_cnt=1 with macro.
REQ-030 Hold 8'h02 with pointld=0 -> num=0, sw_out=8'h00, valid=0; then a 2-cycle pulse to 8'h1F, returning to 8'h02 -> no output change.
REQ-031 hex=8'hAA held 4 cycles -> err=1, sw_out=8'h00, valid=0, num unchanged; then 8'h41 with pointld=1 -> num=6, sw_out=8'h40, err=0.
REQ-032 Change input on the exact edge where cnt would reach STABLE -> no commit on that edge; the new value commits STABLE-1 edges later.
REQ-033 Assert rst one cycle during SETTLE with a partial run -> all outputs zero next cycle; the run restarts from 1.
REQ-034 With macro, alternate 8'h9F and 8'h25 with pointld=1, each held 4 cycles, 256 times -> chg_cnt wraps to 0; same commit repeated -> no increment; without macro -> chg_cnt stays 0.
